// File: rtl/flux_frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// flux_frame_sequencer_pkg
// Shared definitions for the flux frame sequencer:
//   - seq_state_e    : sequencer FSM state encoding
//   - flux_t         : default-width flux / running-average word
//   - *_DEFAULT      : default bin width, flux width, absolute beat floor and
//                      WAIT_DONE timeout
//   - HOLDOFF_LOAD   : frames a beat blocks further beats for (only used when
//                      BEAT_HOLDOFF_EN is defined)
// ---------------------------------------------------------------------------
package flux_frame_sequencer_pkg;

    localparam int BIN_W_DEFAULT    = 16;
    localparam int FLUX_W_DEFAULT   = 32;
    localparam int MIN_FLUX_DEFAULT = 256;
    localparam int TIMEOUT_DEFAULT  = 64;

    localparam logic [1:0] HOLDOFF_LOAD = 2'd2;

    typedef logic [FLUX_W_DEFAULT-1:0] flux_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2,
        EVAL      = 2'd3
    } seq_state_e;

endpackage

// File: rtl/flux_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// flux_frame_sequencer_if
// Valid/ready bin stream feeding the sequencer.
//   bin_valid : source has a bin magnitude-squared word on bin_data
//   bin_data  : W-bit bin magnitude-squared
//   bin_ready : sequencer accepts the bin this cycle
// Modports: master (bin source), slave (sequencer).
// ---------------------------------------------------------------------------
interface flux_frame_sequencer_if
    import flux_frame_sequencer_pkg::*;
#(
    parameter int W = BIN_W_DEFAULT
);
    logic         bin_valid;
    logic [W-1:0] bin_data;
    logic         bin_ready;

    modport master (
        output bin_valid,
        output bin_data,
        input  bin_ready
    );

    modport slave (
        input  bin_valid,
        input  bin_data,
        output bin_ready
    );
endinterface

// File: rtl/flux_threshold_avg.sv
// ---------------------------------------------------------------------------
// flux_threshold_avg
// Running flux average and adaptive beat threshold.
//   clk       : clock
//   reset     : asynchronous, active-low; clears the average
//   flux      : frame flux under evaluation
//   update    : one-cycle strobe; folds flux into the average at this edge
//   avg       : current running average (registered)
//   above_thr : flux > avg + (avg >> THR_SHIFT), threshold saturating at
//               all-ones; evaluated against the pre-update average
// Average update: avg - (avg >> AVG_SHIFT) + (flux >> AVG_SHIFT), truncating.
// The subtraction cannot underflow, and the sum is clamped in case the
// rounding ever pushes it past the word width.
// ---------------------------------------------------------------------------
module flux_threshold_avg
    import flux_frame_sequencer_pkg::*;
#(
    parameter int FW        = FLUX_W_DEFAULT,
    parameter int AVG_SHIFT = 3,
    parameter int THR_SHIFT = 1
)(
    input  logic          clk,
    input  logic          reset,
    input  logic [FW-1:0] flux,
    input  logic          update,
    output logic [FW-1:0] avg,
    output logic          above_thr
);

    logic [FW-1:0] avg_q;
    logic [FW-1:0] avg_d;
    logic [FW-1:0] thr;
    logic [FW:0]   thr_sum;
    logic [FW:0]   avg_sum;

    always_comb begin
        thr_sum   = {1'b0, avg_q} + {1'b0, (avg_q >> THR_SHIFT)};
        thr       = thr_sum[FW] ? {FW{1'b1}} : thr_sum[FW-1:0];
        above_thr = (flux > thr);

        avg_sum   = {1'b0, (avg_q - (avg_q >> AVG_SHIFT))} + {1'b0, (flux >> AVG_SHIFT)};
        avg_d     = avg_q;
        if (update) begin
            avg_d = avg_sum[FW] ? {FW{1'b1}} : avg_sum[FW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avg_q <= '0;
        end else begin
            avg_q <= avg_d;
        end
    end

    assign avg = avg_q;

endmodule

// File: rtl/flux_frame_sequencer.sv
// ---------------------------------------------------------------------------
// flux_frame_sequencer
// Streams N bins per frame into the spectral_flux datapath, waits for the
// frame's flux, and decides whether the frame is a beat.
//
// Ports:
//   clk            : sole clock
//   reset          : asynchronous, active-low; forces IDLE and clears all
//                    outputs, the average, counters and holdoff
//   enable         : run request (sampled in IDLE and at the end of EVAL)
//   bin_bus        : slave side of the bin valid/ready stream
//   mag_valid      : registered copy of each accepted bin, 1 cycle later
//   mag_sq         : bin data for the spectral_flux datapath
//   sf_frame_done  : spectral_flux finished the frame (only honoured in
//                    WAIT_DONE)
//   sf_flux_accum  : frame flux from spectral_flux
//   beat           : one-cycle pulse after an EVAL that qualified as a beat
//   beat_strength  : flux of the most recent beat
//   frame_count    : evaluated frames, wraps at 2^16
//   busy           : FSM not in IDLE
//   timeout_err    : sticky; WAIT_DONE ran TIMEOUT cycles without a flux
//
// Build option: define BEAT_HOLDOFF_EN to block beats for the two frames
// following a beat (the average keeps updating during holdoff).
//
// All outputs are registered and track the next FSM state, so e.g.
// bin_ready falls on the same edge that moves the FSM out of STREAM.
// ---------------------------------------------------------------------------
module flux_frame_sequencer
    import flux_frame_sequencer_pkg::*;
#(
    parameter int W               = BIN_W_DEFAULT,
    parameter int N               = 8,
    parameter int MAX_FLUX_LENGTH = FLUX_W_DEFAULT,
    parameter int AVG_SHIFT       = 3,
    parameter int THR_SHIFT       = 1,
    parameter int MIN_FLUX        = MIN_FLUX_DEFAULT,
    parameter int TIMEOUT         = TIMEOUT_DEFAULT
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    flux_frame_sequencer_if.slave      bin_bus,
    output logic                       mag_valid,
    output logic [W-1:0]               mag_sq,
    input  logic                       sf_frame_done,
    input  logic [MAX_FLUX_LENGTH-1:0] sf_flux_accum,
    output logic                       beat,
    output logic [MAX_FLUX_LENGTH-1:0] beat_strength,
    output logic [15:0]                frame_count,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int FW = MAX_FLUX_LENGTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [FW-1:0] MIN_FLUX_V = FW'(MIN_FLUX);

    seq_state_e     state_q, state_d;
    logic [CW-1:0]  bin_cnt_q, bin_cnt_d;
    logic [TW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [FW-1:0]  flux_q, flux_d;
    logic           bin_ready_q, bin_ready_d;
    logic           busy_q, busy_d;
    logic           mag_valid_q, mag_valid_d;
    logic [W-1:0]   mag_sq_q, mag_sq_d;
    logic           beat_q, beat_d;
    logic [FW-1:0]  beat_strength_q, beat_strength_d;
    logic [15:0]    frame_count_q, frame_count_d;
    logic           timeout_err_q, timeout_err_d;
`ifdef BEAT_HOLDOFF_EN
    logic [1:0]     holdoff_q, holdoff_d;
`endif

    logic           accept;
    logic           beat_fire;
    logic           avg_update;
    logic           above_thr;
    logic [FW-1:0]  avg;

    // Average/threshold see the captured frame flux; the strobe is the EVAL
    // cycle, so the threshold compare uses the average from before this frame.
    flux_threshold_avg #(
        .FW        (FW),
        .AVG_SHIFT (AVG_SHIFT),
        .THR_SHIFT (THR_SHIFT)
    ) u_thr_avg (
        .clk       (clk),
        .reset     (reset),
        .flux      (flux_q),
        .update    (avg_update),
        .avg       (avg),
        .above_thr (above_thr)
    );

    always_comb begin
        accept          = bin_ready_q && bin_bus.bin_valid;

        state_d         = state_q;
        bin_cnt_d       = bin_cnt_q;
        wait_cnt_d      = wait_cnt_q;
        flux_d          = flux_q;
        mag_valid_d     = accept;
        mag_sq_d        = accept ? bin_bus.bin_data : mag_sq_q;
        beat_d          = 1'b0;
        beat_strength_d = beat_strength_q;
        frame_count_d   = frame_count_q;
        timeout_err_d   = timeout_err_q;
        avg_update      = 1'b0;
        beat_fire       = 1'b0;
`ifdef BEAT_HOLDOFF_EN
        holdoff_d       = holdoff_q;
`endif

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = STREAM;
                end
            end

            // enable is deliberately ignored here: a frame, once started,
            // always runs to all N bins.
            STREAM: begin
                if (accept) begin
                    if (bin_cnt_q == CNT_LAST) begin
                        bin_cnt_d = '0;
                        state_d   = WAIT_DONE;
                    end else begin
                        bin_cnt_d = bin_cnt_q + CW'(1);
                    end
                end
            end

            // A late sf_frame_done still wins on the last wait cycle.
            WAIT_DONE: begin
                if (sf_frame_done) begin
                    flux_d     = sf_flux_accum;
                    wait_cnt_d = '0;
                    state_d    = EVAL;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d    = '0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end

            EVAL: begin
                avg_update = 1'b1;
                beat_fire  = above_thr && (flux_q > MIN_FLUX_V);
`ifdef BEAT_HOLDOFF_EN
                if (holdoff_q != 2'd0) begin
                    beat_fire = 1'b0;
                    holdoff_d = holdoff_q - 2'd1;
                end
                if (beat_fire) begin
                    holdoff_d = HOLDOFF_LOAD;
                end
`endif
                beat_d = beat_fire;
                if (beat_fire) begin
                    beat_strength_d = flux_q;
                end
                frame_count_d = frame_count_q + 16'd1;
                state_d       = enable ? STREAM : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        bin_ready_d = (state_d == STREAM);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            bin_cnt_q       <= '0;
            wait_cnt_q      <= '0;
            flux_q          <= '0;
            bin_ready_q     <= 1'b0;
            busy_q          <= 1'b0;
            mag_valid_q     <= 1'b0;
            mag_sq_q        <= '0;
            beat_q          <= 1'b0;
            beat_strength_q <= '0;
            frame_count_q   <= '0;
            timeout_err_q   <= 1'b0;
`ifdef BEAT_HOLDOFF_EN
            holdoff_q       <= 2'd0;
`endif
        end else begin
            state_q         <= state_d;
            bin_cnt_q       <= bin_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            flux_q          <= flux_d;
            bin_ready_q     <= bin_ready_d;
            busy_q          <= busy_d;
            mag_valid_q     <= mag_valid_d;
            mag_sq_q        <= mag_sq_d;
            beat_q          <= beat_d;
            beat_strength_q <= beat_strength_d;
            frame_count_q   <= frame_count_d;
            timeout_err_q   <= timeout_err_d;
`ifdef BEAT_HOLDOFF_EN
            holdoff_q       <= holdoff_d;
`endif
        end
    end

    assign bin_bus.bin_ready = bin_ready_q;
    assign mag_valid         = mag_valid_q;
    assign mag_sq            = mag_sq_q;
    assign beat              = beat_q;
    assign beat_strength     = beat_strength_q;
    assign frame_count       = frame_count_q;
    assign busy              = busy_q;
    assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_flux_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_flux_frame_sequencer
// Frame-level table of {bin base, flux, expected beat/strength/avg/count}
// plus hand-written sequences for timeout, enable drop and mid-frame reset.
// Every accepted bin is pushed onto a queue and must reappear on
// mag_valid/mag_sq exactly one cycle later.
// ---------------------------------------------------------------------------
module tb_flux_frame_sequencer;
    import flux_frame_sequencer_pkg::*;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int FW = 32;
`ifdef BEAT_HOLDOFF_EN
    localparam bit HO = 1'b1;
`else
    localparam bit HO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          mag_valid;
    logic [W-1:0]  mag_sq;
    logic          sf_frame_done = 1'b0;
    logic [FW-1:0] sf_flux_accum = '0;
    logic          beat;
    logic [FW-1:0] beat_strength;
    logic [15:0]   frame_count;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    flux_frame_sequencer_if #(.W(W)) bin_bus ();

    flux_frame_sequencer #(
        .W(W), .N(N), .MAX_FLUX_LENGTH(FW), .AVG_SHIFT(3), .THR_SHIFT(1),
        .MIN_FLUX(256), .TIMEOUT(64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .bin_bus       (bin_bus),
        .mag_valid     (mag_valid),
        .mag_sq        (mag_sq),
        .sf_frame_done (sf_frame_done),
        .sf_flux_accum (sf_flux_accum),
        .beat          (beat),
        .beat_strength (beat_strength),
        .frame_count   (frame_count),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int mag_seen = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: anything pushed after an accept edge must show up at the
    // very next negedge.
    always @(negedge clk) begin
        if (reset && (mag_valid || exp_q.size() != 0)) begin
            logic [W-1:0] e;
            check("mag_valid_lat1", mag_valid, 1);
            check("mag_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (mag_valid) check("mag_sq", mag_sq, e);
            end
            if (mag_valid) mag_seen++;
        end
    end

    task automatic apply_reset();
        reset = 1'b0;
        enable = 1'b0;
        bin_bus.bin_valid = 1'b0;
        sf_frame_done = 1'b0;
        #1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_bin_ready", bin_bus.bin_ready, 0);
        check("rst_mag_valid", mag_valid, 0);
        check("rst_mag_sq", mag_sq, 0);
        check("rst_beat", beat, 0);
        check("rst_strength", beat_strength, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_avg", dut.avg, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Offer `count` bins; enable is dropped just before bin index drop_at.
    task automatic send_bins(input logic [W-1:0] base, input int count, input int drop_at);
        for (int i = 0; i < count; i++) begin
            int   tries;
            logic rdy;
            logic [W-1:0] d;
            tries = 0;
            if (i == drop_at) enable = 1'b0;
            d = base + W'(i * 3);
            bin_bus.bin_valid = 1'b1;
            bin_bus.bin_data  = d;
            do begin
                rdy = bin_bus.bin_ready;
                @(posedge clk);
                #1;
                tries++;
            end while (!rdy && tries < 20);
            check("bin_accepted", rdy, 1);
            if (rdy) begin
                exp_q.push_back(d);
                check("busy_stream", busy, 1);
            end
        end
        bin_bus.bin_valid = 1'b0;
    endtask

    // Wait gap cycles in WAIT_DONE, pulse sf_frame_done, return after EVAL.
    task automatic finish_frame(input logic [FW-1:0] accum, input int gap);
        check("bin_ready_drop", bin_bus.bin_ready, 0);
        check("busy_wait", busy, 1);
        repeat (gap) @(posedge clk);
        #1;
        sf_frame_done = 1'b1;
        sf_flux_accum = accum;
        @(posedge clk);
        #1;
        sf_frame_done = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          do_reset;
        logic [W-1:0] base;
        flux_t       accum;
        logic        exp_beat;
        flux_t       exp_strength;
        flux_t       exp_avg;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        logic beat_seen;

        vecs[0] = '{1'b1, 16'd500, 32'd3500, 1'b1,      32'd3500, 32'd437, 16'd1};
        vecs[1] = '{1'b0, 16'd500, 32'd0,    1'b0,      32'd3500, 32'd383, 16'd2};
        vecs[2] = '{1'b0, 16'd500, 32'd3500, HO ? 1'b0 : 1'b1, 32'd3500, 32'd773, 16'd3};
        vecs[3] = '{1'b1, 16'd7,   32'd256,  1'b0,      32'd0,    32'd32,  16'd1};
        vecs[4] = '{1'b0, 16'd7,   32'd257,  1'b1,      32'd257,  32'd60,  16'd2};

        bin_bus.bin_valid = 1'b0;
        bin_bus.bin_data  = '0;

        // ---- table-driven frames ----
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_reset) apply_reset();
            enable = 1'b1;
            mag_seen = 0;
            send_bins(vecs[v].base, N, N + 1);
            finish_frame(vecs[v].accum, 2);
            check("frame_beat", beat, vecs[v].exp_beat);
            check("frame_strength", beat_strength, vecs[v].exp_strength);
            check("frame_avg", dut.avg, vecs[v].exp_avg);
            check("frame_count", frame_count, vecs[v].exp_count);
            check("frame_mag_pulses", mag_seen, N);
            @(posedge clk);
            #1;
            check("beat_one_cycle", beat, 0);
            check("back_to_stream", bin_bus.bin_ready, 1);
            $display("frame %0d: flux=%0d beat=%0d strength=%0d avg=%0d count=%0d",
                     v, vecs[v].accum, beat_strength == vecs[v].exp_strength ? vecs[v].exp_beat : 1'bx,
                     beat_strength, dut.avg, frame_count);
        end

        // ---- timeout: no sf_frame_done ----
        apply_reset();
        enable = 1'b1;
        send_bins(16'd10, N, N + 1);
        enable = 1'b0;
        n = 0;
        beat_seen = 1'b0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (beat) beat_seen = 1'b1;
        end
        check("timeout_cycles", n, 64);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_busy", busy, 0);
        check("timeout_bin_ready", bin_bus.bin_ready, 0);
        check("timeout_no_beat", beat_seen, 0);
        check("timeout_frame_count", frame_count, 0);
        $display("timeout: waited %0d cycles, timeout_err=%0d", n, timeout_err);

        // sf_frame_done while IDLE must be ignored
        sf_frame_done = 1'b1;
        sf_flux_accum = 32'd5000;
        @(posedge clk);
        #1;
        sf_frame_done = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done_count", frame_count, 0);
        check("idle_done_beat", beat, 0);
        check("idle_done_busy", busy, 0);

        // timeout_err stays set through a normal frame
        enable = 1'b1;
        send_bins(16'd20, N, N + 1);
        enable = 1'b0;
        finish_frame(32'd200, 0);
        check("sticky_timeout_err", timeout_err, 1);
        check("post_timeout_count", frame_count, 1);
        $display("post-timeout frame: count=%0d timeout_err=%0d", frame_count, timeout_err);

        // ---- enable dropped after 3 bins ----
        apply_reset();
        enable = 1'b1;
        mag_seen = 0;
        send_bins(16'd100, N, 3);
        finish_frame(32'd200, 1);
        check("drop_mag_pulses", mag_seen, N);
        check("drop_frame_count", frame_count, 1);
        check("drop_beat_floor", beat, 0);
        check("drop_avg", dut.avg, 25);
        check("drop_busy", busy, 0);
        @(posedge clk);
        #1;
        check("drop_stays_idle", busy, 0);
        check("drop_bin_ready", bin_bus.bin_ready, 0);
        $display("enable-drop: pulses=%0d count=%0d busy=%0d", mag_seen, frame_count, busy);

        // ---- reset mid-STREAM ----
        enable = 1'b1;
        send_bins(16'd300, 4, N + 1);
        check("pre_rst_mag_valid", mag_valid, 1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_bin_ready", bin_bus.bin_ready, 0);
        check("midrst_mag_valid", mag_valid, 0);
        check("midrst_beat", beat, 0);
        check("midrst_frame_count", frame_count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_avg", dut.avg, 0);
        $display("mid-frame reset: bin_ready=%0d mag_valid=%0d count=%0d", bin_bus.bin_ready, mag_valid, frame_count);
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // first frame after reset sees avg=0 and a fresh bin counter
        enable = 1'b1;
        mag_seen = 0;
        send_bins(16'd500, N, N + 1);
        enable = 1'b0;
        finish_frame(32'd3500, 3);
        check("after_rst_beat", beat, 1);
        check("after_rst_strength", beat_strength, 3500);
        check("after_rst_avg", dut.avg, 437);
        check("after_rst_count", frame_count, 1);
        check("after_rst_pulses", mag_seen, N);
        $display("post-reset frame: beat=%0d avg=%0d count=%0d", beat, dut.avg, frame_count);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

endmodule
